// File: rtl/pipelined_datapath.sv
// ---------------------------------------------------------------------------
// pipelined_datapath
//
// Two-stage execute datapath with a register file, immediate/register operand
// select, an ALU and writeback. Decoded instructions arrive through a
// valid/ready handshake. Operands are read in ID and latched into the EX
// registers. At the edge that ends EX, the ALU result is registered onto the
// output and written back to the register file.
//
// Optional feature (macro DATAPATH_FWD_EN):
//   defined   - the EX result is forwarded combinationally to ID operands.
//   undefined - a dependent instruction is stalled one cycle (interlock).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready instruction handshake
//   rs1, rs2, rd      source/destination register addresses
//   regWrite          write rd at writeback
//   ALUsrc            1 = ImmOp is operand 2, 0 = R[rs2]
//   ImmOp             immediate operand
//   ALUctrl           ALU operation select
//   out_valid         ALUout/eq hold a completed result
//   out_ready         consumer takes the result
//   ALUout, eq        registered ALU result and (op1 == op2)
//   a0                combinational view of register A0_IDX
// ---------------------------------------------------------------------------
module pipelined_datapath #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int A0_IDX  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] rs1,
    input  logic [A_WIDTH-1:0] rs2,
    input  logic [A_WIDTH-1:0] rd,
    input  logic               regWrite,
    input  logic               ALUsrc,
    input  logic [D_WIDTH-1:0] ImmOp,
    input  logic [2:0]         ALUctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] ALUout,
    output logic               eq,
    output logic [D_WIDTH-1:0] a0
);

    localparam int NREG = 2**A_WIDTH;
    localparam int SH_W = $clog2(D_WIDTH);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    // Register file and pipeline state
    logic [D_WIDTH-1:0] r_rf [NREG];

    logic               r_ex_valid;
    logic [D_WIDTH-1:0] r_ex_op1;
    logic [D_WIDTH-1:0] r_ex_op2;
    logic [A_WIDTH-1:0] r_ex_rd;
    logic               r_ex_regwrite;
    alu_op_e            r_ex_ctrl;

    logic               r_out_valid;
    logic [D_WIDTH-1:0] r_alu_out;
    logic               r_eq;

    // Combinational nets
    logic               w_adv;
    logic               w_accept;
    logic               w_ex_writes;
    logic               w_hz_rs1;
    logic               w_hz_rs2;
    logic [D_WIDTH-1:0] w_rf_rs1;
    logic [D_WIDTH-1:0] w_rf_rs2;
    logic [D_WIDTH-1:0] w_op1;
    logic [D_WIDTH-1:0] w_op2;
    logic [D_WIDTH-1:0] w_alu_res;
    logic [SH_W-1:0]    w_shamt;

    // The whole pipeline moves only when the output slot is free or drained.
    assign w_adv = !r_out_valid || out_ready;

    // The EX instruction is the only result not yet in the register file.
    assign w_ex_writes = r_ex_valid && r_ex_regwrite && (r_ex_rd != '0);
    assign w_hz_rs1    = w_ex_writes && (r_ex_rd == rs1);
    assign w_hz_rs2    = w_ex_writes && (r_ex_rd == rs2) && !ALUsrc;

    assign w_rf_rs1 = (rs1 == '0) ? '0 : r_rf[rs1];
    assign w_rf_rs2 = (rs2 == '0) ? '0 : r_rf[rs2];

`ifdef DATAPATH_FWD_EN
    // EX holds during a stall, so the forwarded value stays valid.
    assign w_op1    = w_hz_rs1 ? w_alu_res : w_rf_rs1;
    assign w_op2    = ALUsrc ? ImmOp : (w_hz_rs2 ? w_alu_res : w_rf_rs2);
    assign in_ready = w_adv;
`else
    assign w_op1    = w_rf_rs1;
    assign w_op2    = ALUsrc ? ImmOp : w_rf_rs2;
    assign in_ready = w_adv && !(w_hz_rs1 || w_hz_rs2);
`endif

    assign w_accept = in_valid && in_ready;
    assign w_shamt  = r_ex_op2[SH_W-1:0];

    always_comb begin
        // NOTE: default assignment first so no path leaves w_alu_res unassigned (no latch).
        w_alu_res = '0;
        case (r_ex_ctrl)
            ALU_ADD: w_alu_res = r_ex_op1 + r_ex_op2;
            ALU_SUB: w_alu_res = r_ex_op1 - r_ex_op2;
            ALU_AND: w_alu_res = r_ex_op1 & r_ex_op2;
            ALU_OR:  w_alu_res = r_ex_op1 | r_ex_op2;
            ALU_XOR: w_alu_res = r_ex_op1 ^ r_ex_op2;
            ALU_SLT: w_alu_res = {{(D_WIDTH-1){1'b0}},
                                  ($signed(r_ex_op1) < $signed(r_ex_op2))};
            ALU_SLL: w_alu_res = r_ex_op1 << w_shamt;
            ALU_SRL: w_alu_res = r_ex_op1 >> w_shamt;
            default: w_alu_res = '0;
        endcase
    end

    // Register file: written at the result edge by the EX instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file must come out of reset all-zero, so every entry is cleared here.
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_adv && w_ex_writes) begin
            // NOTE: non-blocking so reads in this same edge see the old value.
            r_rf[r_ex_rd] <= w_alu_res;
        end
    end

    // EX stage: load a new instruction, or a bubble when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_op1      <= '0;
            r_ex_op2      <= '0;
            r_ex_rd       <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_ctrl     <= ALU_ADD;
        end else if (w_adv) begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_op1      <= w_op1;
                r_ex_op2      <= w_op2;
                r_ex_rd       <= rd;
                r_ex_regwrite <= regWrite;
                r_ex_ctrl     <= alu_op_e'(ALUctrl);
            end
        end
    end

    // Output stage: result registers, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_eq        <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_ex_valid;
            r_alu_out   <= w_alu_res;
            r_eq        <= (r_ex_op1 == r_ex_op2);
        end
    end

    assign out_valid = r_out_valid;
    assign ALUout    = r_alu_out;
    assign eq        = r_eq;
    assign a0        = r_rf[A_WIDTH'(A0_IDX)];

endmodule

// File: tb/tb_pipelined_datapath.sv
// ---------------------------------------------------------------------------
// tb_pipelined_datapath
//
// Directed self-checking bench for pipelined_datapath with default
// parameters (D_WIDTH=32, A_WIDTH=5, A0_IDX=10). Inputs are driven and
// outputs sampled 1 time unit after each rising edge. Expectations for the
// dependency scenario follow DATAPATH_FWD_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_pipelined_datapath;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  rd = '0;
    logic        regWrite = 1'b0;
    logic        ALUsrc = 1'b0;
    logic [31:0] ImmOp = '0;
    logic [2:0]  ALUctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALUout;
    logic        eq;
    logic [31:0] a0;

    int checks = 0;
    int failures = 0;

    pipelined_datapath #(.D_WIDTH(32), .A_WIDTH(5), .A0_IDX(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .regWrite  (regWrite),
        .ALUsrc    (ALUsrc),
        .ImmOp     (ImmOp),
        .ALUctrl   (ALUctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUout    (ALUout),
        .eq        (eq),
        .a0        (a0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] f_rd, input logic [4:0] f_rs1,
                             input logic [4:0] f_rs2, input logic f_src,
                             input logic [31:0] f_imm, input logic [2:0] f_op,
                             input logic f_we);
        in_valid = 1'b1;
        rd       = f_rd;
        rs1      = f_rs1;
        rs2      = f_rs2;
        ALUsrc   = f_src;
        ImmOp    = f_imm;
        ALUctrl  = f_op;
        regWrite = f_we;
        #1;
    endtask

    task automatic clear_instr();
        in_valid = 1'b0;
        regWrite = 1'b0;
        #1;
    endtask

    // Issue one instruction, wait (bounded) for its result, compare, drain.
    task automatic run_one(input string name, input logic [4:0] f_rd,
                           input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                           input logic f_src, input logic [31:0] f_imm,
                           input logic [2:0] f_op, input logic f_we,
                           input logic [31:0] exp_alu, input logic exp_eq);
        int n;
        set_instr(f_rd, f_rs1, f_rs2, f_src, f_imm, f_op, f_we);
        n = 0;
        while (!in_ready && n < 8) begin step(); n++; end
        step();
        clear_instr();
        n = 0;
        while (!out_valid && n < 8) begin step(); n++; end
        checks++;
        if (out_valid !== 1'b1 || ALUout !== exp_alu || eq !== exp_eq) begin
            failures++;
            $display("FAIL %s: out_valid=%0b ALUout=%08h eq=%0b, expected out_valid=1 ALUout=%08h eq=%0b",
                     name, out_valid, ALUout, eq, exp_alu, exp_eq);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (ALUout !== 32'h0) begin failures++; $display("FAIL reset_ALUout: got %08h expected 0", ALUout); end
        checks++; if (a0 !== 32'h0) begin failures++; $display("FAIL reset_a0: got %08h expected 0", a0); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid: got %0b expected 0", out_valid); end
    endtask

    task automatic test_imm_add();
        set_instr(5'd10, 5'd0, 5'd0, 1'b1, 32'd5, 3'b000, 1'b1);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL imm_in_ready: got %0b expected 1", in_ready); end
        step();
        clear_instr();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL imm_latency1: out_valid=%0b expected 0 after one edge", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL imm_out_valid: got %0b expected 1", out_valid); end
        checks++; if (ALUout !== 32'd5) begin failures++; $display("FAIL imm_ALUout: got %08h expected 00000005", ALUout); end
        checks++; if (eq !== 1'b0) begin failures++; $display("FAIL imm_eq: got %0b expected 0", eq); end
        checks++; if (a0 !== 32'd5) begin failures++; $display("FAIL imm_a0: got %08h expected 00000005", a0); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL imm_drain: out_valid=%0b expected 0", out_valid); end
    endtask

    // x1 = 0 + 7, then x2 = x1 + x1 on the very next cycle.
    task automatic test_back_to_back();
        out_ready = 1'b1;
        set_instr(5'd1, 5'd0, 5'd0, 1'b1, 32'd7, 3'b000, 1'b1);
        step();
        set_instr(5'd2, 5'd1, 5'd1, 1'b0, 32'd0, 3'b000, 1'b1);
`ifdef DATAPATH_FWD_EN
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready: got %0b expected 1", in_ready); end
        step();
        clear_instr();
        checks++; if (out_valid !== 1'b1 || ALUout !== 32'd7) begin failures++; $display("FAIL b2b_first: valid=%0b ALUout=%08h expected 1/00000007", out_valid, ALUout); end
        step();
        checks++; if (out_valid !== 1'b1 || ALUout !== 32'd14) begin failures++; $display("FAIL b2b_second: valid=%0b ALUout=%08h expected 1/0000000e", out_valid, ALUout); end
        step();
`else
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_interlock: in_ready=%0b expected 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || ALUout !== 32'd7) begin failures++; $display("FAIL b2b_first: valid=%0b ALUout=%08h expected 1/00000007", out_valid, ALUout); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_release: in_ready=%0b expected 1", in_ready); end
        step();
        clear_instr();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap: out_valid=%0b expected 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || ALUout !== 32'd14) begin failures++; $display("FAIL b2b_second: valid=%0b ALUout=%08h expected 1/0000000e", out_valid, ALUout); end
        step();
`endif
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: out_valid=%0b expected 0", out_valid); end
    endtask

    // A: x10 = x10 + 1 (=6), B: x11 = 20, C: x12 = 30, stall with A on output.
    task automatic test_backpressure();
        out_ready = 1'b1;
        set_instr(5'd10, 5'd10, 5'd0, 1'b1, 32'd1, 3'b000, 1'b1);
        step();
        set_instr(5'd11, 5'd0, 5'd0, 1'b1, 32'd20, 3'b000, 1'b1);
        step();
        out_ready = 1'b0;
        set_instr(5'd12, 5'd0, 5'd0, 1'b1, 32'd30, 3'b000, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || ALUout !== 32'd6 || eq !== 1'b0 || a0 !== 32'd6) begin
                failures++;
                $display("FAIL bp_hold%0d: in_ready=%0b valid=%0b ALUout=%08h eq=%0b a0=%08h expected 0/1/00000006/0/00000006",
                         c, in_ready, out_valid, ALUout, eq, a0);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_resume_ready: got %0b expected 1", in_ready); end
        step();
        clear_instr();
        checks++; if (out_valid !== 1'b1 || ALUout !== 32'd20) begin failures++; $display("FAIL bp_B: valid=%0b ALUout=%08h expected 1/00000014", out_valid, ALUout); end
        step();
        checks++; if (out_valid !== 1'b1 || ALUout !== 32'd30) begin failures++; $display("FAIL bp_C: valid=%0b ALUout=%08h expected 1/0000001e", out_valid, ALUout); end
        checks++; if (a0 !== 32'd6) begin failures++; $display("FAIL bp_a0: got %08h expected 00000006", a0); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: out_valid=%0b expected 0", out_valid); end
        run_one("bp_regs_sum", 5'd13, 5'd11, 5'd12, 1'b0, 32'd0, 3'b000, 1'b1, 32'd50, 1'b0);
    endtask

    task automatic test_alu_ops();
        run_one("sub_0_1",   5'd5,  5'd0,  5'd0, 1'b1, 32'd1,    3'b001, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_one("add_wrap",  5'd19, 5'd5,  5'd0, 1'b1, 32'd2,    3'b000, 1'b1, 32'h0000_0001, 1'b0);
        run_one("slt_m1_1",  5'd6,  5'd5,  5'd0, 1'b1, 32'd1,    3'b101, 1'b1, 32'h0000_0001, 1'b0);
        run_one("slt_1_m1",  5'd15, 5'd6,  5'd5, 1'b0, 32'd0,    3'b101, 1'b1, 32'h0000_0000, 1'b0);
        run_one("sll_1_33",  5'd7,  5'd6,  5'd0, 1'b1, 32'd33,   3'b110, 1'b1, 32'h0000_0002, 1'b0);
        run_one("srl_4",     5'd16, 5'd5,  5'd0, 1'b1, 32'd4,    3'b111, 1'b1, 32'h0FFF_FFFF, 1'b0);
        run_one("and_f0",    5'd17, 5'd5,  5'd0, 1'b1, 32'hF0,   3'b010, 1'b1, 32'h0000_00F0, 1'b0);
        run_one("or_0f",     5'd18, 5'd17, 5'd0, 1'b1, 32'h0F,   3'b011, 1'b1, 32'h0000_00FF, 1'b0);
        run_one("set_x9",    5'd9,  5'd0,  5'd0, 1'b1, 32'd5,    3'b000, 1'b1, 32'h0000_0005, 1'b0);
        run_one("xor_eq_5",  5'd8,  5'd9,  5'd0, 1'b1, 32'd5,    3'b100, 1'b1, 32'h0000_0000, 1'b1);
        run_one("x0_write",  5'd0,  5'd0,  5'd0, 1'b1, 32'h55,   3'b000, 1'b1, 32'h0000_0055, 1'b0);
        run_one("x0_read",   5'd14, 5'd0,  5'd0, 1'b0, 32'd0,    3'b000, 1'b1, 32'h0000_0000, 1'b1);
    endtask

    // P (x20 = 0x77) reaches the output, Q (x10 = 0x99) sits in EX; then reset.
    task automatic test_reset_midflight();
        out_ready = 1'b1;
        set_instr(5'd20, 5'd0, 5'd0, 1'b1, 32'h77, 3'b000, 1'b1);
        step();
        set_instr(5'd10, 5'd0, 5'd0, 1'b1, 32'h99, 3'b000, 1'b1);
        step();
        clear_instr();
        checks++; if (out_valid !== 1'b1 || ALUout !== 32'h77) begin failures++; $display("FAIL mid_pre: valid=%0b ALUout=%08h expected 1/00000077", out_valid, ALUout); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || ALUout !== 32'h0 || a0 !== 32'h0) begin failures++; $display("FAIL mid_async: valid=%0b ALUout=%08h a0=%08h expected 0/0/0", out_valid, ALUout, a0); end
        step();
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || a0 !== 32'h0) begin
                failures++;
                $display("FAIL mid_discard%0d: valid=%0b a0=%08h expected 0/00000000", c, out_valid, a0);
            end
        end
        run_one("mid_x20_zero", 5'd21, 5'd20, 5'd0, 1'b1, 32'd0, 3'b000, 1'b1, 32'h0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_imm_add();
        test_back_to_back();
        test_backpressure();
        test_alu_ops();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
